// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, access size
// decode, FSM state encoding and the misalignment predicate.
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE,
    ERR
  } lsu_state_e;

  // Reserved funct3 encodings fall through to a word access.
  function automatic lsu_size_e size_of(input logic [2:0] funct3);
    case (funct3)
      F3_BYTE, F3_BYTEU: size_of = SZ_BYTE;
      F3_HALF, F3_HALFU: size_of = SZ_HALF;
      F3_WORD:           size_of = SZ_WORD;
      default:           size_of = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (size_of(funct3))
      SZ_HALF: is_misaligned = addr_lo[0];
      SZ_WORD: is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data TCM request/grant/response bus; master is the LSU, slave is the memory.
interface lsu_ctrl_if;

  logic        dtcm_req;
  logic        dtcm_gnt;
  logic        dtcm_we;
  logic [31:0] dtcm_addr;
  logic [3:0]  dtcm_be;
  logic [31:0] dtcm_wdata;
  logic        dtcm_rvalid;
  logic [31:0] dtcm_rdata;

  modport master (
    output dtcm_req, dtcm_we, dtcm_addr, dtcm_be, dtcm_wdata,
    input  dtcm_gnt, dtcm_rvalid, dtcm_rdata
  );

  modport slave (
    input  dtcm_req, dtcm_we, dtcm_addr, dtcm_be, dtcm_wdata,
    output dtcm_gnt, dtcm_rvalid, dtcm_rdata
  );

endinterface

// File: rtl/lsu_ctrl_align.sv
// lsu_align: combinational byte-enable generation, store data replication and
// load lane extraction with sign/zero extension.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        is_unsigned;

  // funct3[2] marks the zero-extending load variants.
  always_comb begin
    be_o        = 4'b1111;
    wdata_o     = wdata_i;
    rdata_o     = rdata_i;
    is_unsigned = funct3_i[2];
    lane_h      = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (addr_lo_i)
      2'b00:   lane_b = rdata_i[7:0];
      2'b01:   lane_b = rdata_i[15:8];
      2'b10:   lane_b = rdata_i[23:16];
      default: lane_b = rdata_i[31:24];
    endcase

    case (size_of(funct3_i))
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = is_unsigned ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = is_unsigned ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding access to the data TCM.
// Optional LSU_MISALIGN_CHECK_EN traps misaligned half/word accesses into ERR.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        lsu_stall,
  output logic [31:0] lsu_rdata,
  output logic        lsu_rdata_valid,
  output logic        lsu_misalign,
  lsu_ctrl_if.master  dtcm
);

  lsu_state_e  state_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic        misalign_q;

  logic        ex_req;
  logic        req_misaligned;
  logic        in_req;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;

  assign ex_req = ex_mem_read | ex_mem_write;

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_misaligned = is_misaligned(ex_funct3, ex_addr[1:0]);
`else
  assign req_misaligned = 1'b0;
`endif

  lsu_align u_align (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (dtcm.dtcm_rdata),
    .be_o      (align_be),
    .wdata_o   (align_wdata),
    .rdata_o   (align_rdata)
  );

  // A simultaneous read and write request is issued as a store.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      funct3_q      <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_req) begin
            addr_q   <= ex_addr;
            funct3_q <= ex_funct3;
            wdata_q  <= ex_wdata;
            we_q     <= ex_mem_write;
            if (req_misaligned) begin
              state_q    <= ERR;
              misalign_q <= 1'b1;
            end else begin
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (dtcm.dtcm_gnt) begin
            state_q <= we_q ? DONE : WAIT_R;
          end
        end
        WAIT_R: begin
          if (dtcm.dtcm_rvalid) begin
            rdata_q       <= align_rdata;
            rdata_valid_q <= 1'b1;
            state_q       <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus qualifiers are gated so nothing but address/data leaks outside REQ.
  assign in_req            = (state_q == REQ);
  assign dtcm.dtcm_req     = in_req;
  assign dtcm.dtcm_we      = in_req & we_q;
  assign dtcm.dtcm_addr    = {addr_q[31:2], 2'b00};
  assign dtcm.dtcm_be      = in_req ? align_be : 4'b0000;
  assign dtcm.dtcm_wdata   = align_wdata;

  assign lsu_stall       = ((state_q == IDLE) && ex_req) || in_req || (state_q == WAIT_R);
  assign lsu_rdata       = rdata_q;
  assign lsu_rdata_valid = rdata_valid_q;
  assign lsu_misalign    = misalign_q;

endmodule
